// File: rtl/stream_tx_port.sv
// stream_tx_port: CPU-written queue driving a valid/ready stream, push-to-valid latency 1 cycle.
// Stalls CPU data writes while full and holds dout under back-pressure. STREAM_TX_GATE_VALID_EN also gates val_out with ready_downward.
module stream_tx_port #(
   parameter int PAYLOAD_BITS = 32,
   parameter int ADDR_BITS    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cpu_we,
   input  logic [1:0]              cpu_addr,
   input  logic [31:0]             cpu_wdata,
   output logic [31:0]             cpu_rdata,
   output logic                    cpu_stall,
   output logic [PAYLOAD_BITS-1:0] dout,
   output logic                    val_out,
   input  logic                    ready_downward
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);

   logic [PAYLOAD_BITS-1:0] mem [DEPTH];
   logic [ADDR_BITS-1:0]    rd_ptr;
   logic [ADDR_BITS-1:0]    wr_ptr;
   logic [ADDR_BITS:0]      count;
   logic [31:0]             txcnt;
   logic                    enable;
   logic                    empty;
   logic                    full;
   logic                    data_wr;
   logic                    push;
   logic                    pop;
   logic                    flush;
   logic                    txcnt_clr;
   logic [PAYLOAD_BITS-1:0] push_word;

   generate
      if (PAYLOAD_BITS > 32) begin : g_wide
         assign push_word = {{(PAYLOAD_BITS-32){1'b0}}, cpu_wdata};
      end else begin : g_narrow
         assign push_word = cpu_wdata[PAYLOAD_BITS-1:0];
      end
   endgenerate

   // Full comes from the registered count, so a pop in the same cycle does not unblock a push.
   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign data_wr   = cpu_we && (cpu_addr == 2'd0);
   assign push      = data_wr && !full;
   assign cpu_stall = data_wr && full;
   assign flush     = cpu_we && (cpu_addr == 2'd3) && cpu_wdata[1];
   assign txcnt_clr = cpu_we && (cpu_addr == 2'd2);

`ifdef STREAM_TX_GATE_VALID_EN
   assign val_out = !empty && enable && ready_downward;
`else
   assign val_out = !empty && enable;
`endif

   assign pop  = val_out && ready_downward;
   assign dout = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A flush does not cancel a same-edge transfer, so TXCNT still counts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txcnt  <= '0;
         enable <= 1'b1;
      end else begin
         if (txcnt_clr) begin
            txcnt <= '0;
         end else if (pop) begin
            txcnt <= txcnt + 1'b1;
         end
         if (cpu_we && (cpu_addr == 2'd3)) begin
            enable <= cpu_wdata[0];
         end
      end
   end

   always_comb begin
      cpu_rdata = '0;
      case (cpu_addr)
         2'd1: begin
            cpu_rdata[0]             = empty;
            cpu_rdata[1]             = full;
            cpu_rdata[8+ADDR_BITS:8] = count;
         end
         2'd2:    cpu_rdata    = txcnt;
         2'd3:    cpu_rdata[0] = enable;
         default: cpu_rdata    = '0;
      endcase
   end

endmodule
